// File: rtl/divu_pkg.sv
// Shared types and defaults for the sequential unsigned divider.
package divu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } divu_state_t;

    localparam int DIVU_DEFAULT_WIDTH = 32;

endpackage

// File: rtl/divu_seq_if.sv
// Operand and result handshakes of divu_seq, bundled as one interface.
interface divu_seq_if
    import divu_pkg::*;
#(
    parameter int WIDTH = DIVU_DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // The requester drives operands and consumes results.
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/divu_seq_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             unused_msbs;

    assign shifted = {rem, next_bit};
    // Top bit of trial is the borrow out of the WIDTH+1-bit subtraction.
    assign trial   = {1'b0, shifted} - {2'b00, divisor};
    assign q_bit   = ~trial[WIDTH+1];

    // Either choice is below the divisor, so the top shifted/difference bit is always zero.
    assign rem_next    = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign unused_msbs = ^{trial[WIDTH], shifted[WIDTH]};

endmodule

// File: rtl/divu_seq.sv
// Iterative unsigned divider: one quotient bit per cycle, valid/ready on both sides.
module divu_seq
    import divu_pkg::*;
#(
    parameter int WIDTH = DIVU_DEFAULT_WIDTH
) (
    input logic       clk,
    input logic       reset,
    divu_seq_if.slave bus
);

    localparam int             CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH - 1);

    divu_state_t      state_q, state_d;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] dq_q;          // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    logic             in_ready;
    logic             out_valid;
    logic             accept;
    logic             finish;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .next_bit (dq_q[WIDTH-1]),
        .divisor  (divisor_q),
        .rem_next (step_rem),
        .q_bit    (step_bit)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        finish    = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = (bus.divisor == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (count_q == LAST_ITER) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Result registers are cleared on reset so an abandoned operation leaves no stale value.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            divisor_q   <= '0;
            dq_q        <= '0;
            rem_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else if (accept) begin
            count_q   <= '0;
            divisor_q <= bus.divisor;
            dq_q      <= bus.dividend;
            rem_q     <= '0;
            if (bus.divisor == '0) begin
                quotient_q  <= '1;
                remainder_q <= bus.dividend;
                dbz_q       <= 1'b1;
            end
        end else if (state_q == BUSY) begin
            count_q <= count_q + 1'b1;
            rem_q   <= step_rem;
            dq_q    <= {dq_q[WIDTH-2:0], step_bit};
            if (finish) begin
                quotient_q  <= {dq_q[WIDTH-2:0], step_bit};
                remainder_q <= step_rem;
                dbz_q       <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_divu_seq.sv
// Self-checking bench for divu_seq: directed vector table, handshake corner cases, random sweep.
module tb_divu_seq;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   watch = 1'b0;
    int   total = 0;
    int   bad = 0;

    divu_seq_if #(.WIDTH(W)) bus ();

    divu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, with the zero-divisor convention.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic dbz);
        if (b == 0) begin
            q = '1; r = a; dbz = 1'b1;
        end else begin
            q = a / b; r = a % b; dbz = 1'b0;
        end
    endfunction

    always @(negedge clk) begin
        if (watch) check("ready_valid_exclusive", 64'(bus.in_ready & bus.out_valid), 64'd0);
    end

    // Start and end at a falling edge; the accept edge is the rising edge in between.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_issue", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Returns cycles from the accept edge to the first cycle with out_valid visible.
    task automatic wait_done(input bit noise, output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            if (noise) begin
                bus.in_valid = ~bus.in_valid;
                bus.dividend = $urandom;
                bus.divisor  = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        check("out_valid_seen", 64'(bus.out_valid), 64'd1);
    endtask

    task automatic consume(input int stall);
        logic [W-1:0] q0, r0;
        logic         z0;
        q0 = bus.quotient;
        r0 = bus.remainder;
        z0 = bus.div_by_zero;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_out_valid", 64'(bus.out_valid), 64'd1);
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            check("stall_hold", {bus.quotient, bus.remainder} ^ 64'(bus.div_by_zero),
                  {q0, r0} ^ 64'(z0));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("in_ready_after_consume", 64'(bus.in_ready), 64'd1);
        check("out_valid_after_consume", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        vec_t         vecs[$];
        int           lat;
        logic [W-1:0] eq, er, a, b;
        logic         ez;

        vecs.push_back('{32'd100,        32'd7,          32'd14,         32'd2,   1'b0, W + 1});
        vecs.push_back('{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,   1'b0, W + 1});
        vecs.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,   1'b0, W + 1});
        vecs.push_back('{32'd3,          32'd10,         32'd0,          32'd3,   1'b0, W + 1});
        vecs.push_back('{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,   1'b1, 1});
        vecs.push_back('{32'd0,          32'd9,          32'd0,          32'd0,   1'b0, W + 1});
        vecs.push_back('{32'h8000_0000,  32'h8000_0001,  32'd0,          32'h8000_0000, 1'b0, W + 1});
        vecs.push_back('{32'd1000,       32'd10,         32'd100,        32'd0,   1'b0, W + 1});

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        watch = 1'b1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_quotient", 64'(bus.quotient), 64'd0);
        check("rst_remainder", 64'(bus.remainder), 64'd0);
        check("rst_dbz", 64'(bus.div_by_zero), 64'd0);

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b);
            wait_done(1'b0, lat);
            check("vec_latency", 64'(lat), 64'(vecs[i].lat));
            check("vec_quotient", 64'(bus.quotient), 64'(vecs[i].q));
            check("vec_remainder", 64'(bus.remainder), 64'(vecs[i].r));
            check("vec_dbz", 64'(bus.div_by_zero), 64'(vecs[i].dbz));
            consume(0);
        end

        // Backpressure: DONE held for five cycles.
        issue(32'd100, 32'd7);
        wait_done(1'b0, lat);
        consume(5);

        // Operand noise while BUSY must not disturb the captured pair.
        issue(32'd100, 32'd7);
        wait_done(1'b1, lat);
        check("noise_latency", 64'(lat), 64'(W + 1));
        check("noise_quotient", 64'(bus.quotient), 64'd14);
        check("noise_remainder", 64'(bus.remainder), 64'd2);
        consume(1);

        // Reset ten cycles into BUSY abandons the operation.
        issue(32'd77, 32'd5);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_outputs", {bus.quotient, bus.remainder} | 64'(bus.div_by_zero), 64'd0);
        issue(32'd1000, 32'd10);
        wait_done(1'b0, lat);
        check("midrst_latency", 64'(lat), 64'(W + 1));
        check("midrst_quotient", 64'(bus.quotient), 64'd100);
        check("midrst_remainder", 64'(bus.remainder), 64'd0);
        consume(0);

        for (int n = 0; n < 1000; n++) begin
            a = $urandom >> $urandom_range(0, 31);
            b = $urandom >> $urandom_range(0, 31);
            if (b == 0) b = 32'd1;
            ref_div(a, b, eq, er, ez);
            issue(a, b);
            wait_done(1'b0, lat);
            check("rnd_latency", 64'(lat), 64'(W + 1));
            check("rnd_quotient", 64'(bus.quotient), 64'(eq));
            check("rnd_remainder", 64'(bus.remainder), 64'(er));
            check("rnd_dbz", 64'(bus.div_by_zero), 64'(ez));
            check("rnd_identity", 64'(bus.quotient) * 64'(b) + 64'(bus.remainder), 64'(a));
            check("rnd_rem_lt_div", 64'(bus.remainder < b), 64'd1);
            consume($urandom_range(0, 3));
        end

        watch = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
